// File: rtl/looper_pkg.sv
// Shared types and arithmetic for the SRAM audio looper.
// Holds the looper mode and access-state encodings plus the overdub mix helper.
package looper_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2,
        MODE_DUB  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_READ  = 2'd1,
        A_TURN  = 2'd2,
        A_WRITE = 2'd3
    } acc_state_e;

    // Access kinds requested by the mode logic; OP_RMW is the overdub read-mix-write.
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2
    } acc_op_e;

    // Signed 16-bit add clamped to [-32768, 32767].
    function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: one read, write or read-mix-write per request, with
// strobe generation derived from the registered access state.
module sram_access_seq
    import looper_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  acc_op_e           i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_valid,
    output logic [15:0]       o_rdata,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [15:0]       o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq_in,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

    acc_state_e        state_q, state_d;
    acc_op_e           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done;
    logic              in_access;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        done       = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (i_req) begin
                    op_d    = i_op;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    cnt_d   = '0;
                    state_d = (i_op == OP_WRITE) ? A_WRITE : A_READ;
                end
            end
            A_READ: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d    = i_sram_dq_in;
                    rd_valid_d = 1'b1;
                    cnt_d      = '0;
                    // Overdub reuses wdata_q: it held the live input, now it holds the mix.
                    if (op_q == OP_RMW) begin
                        wdata_d = sat16_add(i_sram_dq_in, wdata_q);
                        state_d = A_TURN;
                    end else begin
                        state_d = A_IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            A_TURN: begin
                cnt_d   = '0;
                state_d = A_WRITE;
            end
            A_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = A_IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= A_IDLE;
            op_q       <= OP_READ;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        in_access     = (state_q == A_READ) || (state_q == A_WRITE);
        o_SRAM_CE_N   = ~in_access;
        o_SRAM_LB_N   = ~in_access;
        o_SRAM_UB_N   = ~in_access;
        o_SRAM_OE_N   = (state_q != A_READ);
        o_SRAM_WE_N   = (state_q != A_WRITE);
        o_sram_dq_oe  = (state_q == A_WRITE);
        o_sram_dq_out = wdata_q;
        o_SRAM_ADDR   = addr_q;
        o_busy        = (state_q != A_IDLE);
        o_done        = done;
        o_rd_valid    = rd_valid_q;
        o_rdata       = rdata_q;
    end

endmodule

// File: rtl/sram_loop_ctrl.sv
// Single-track SRAM looper: mode FSM, loop pointer/length and per-sample access
// requests; bus sequencing is delegated to sram_access_seq.
module sram_loop_ctrl
    import looper_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 20,
    parameter logic [ADDR_W-1:0] MAX_LEN = 20'hFFFFF,
    parameter int unsigned       RD_WAIT = 2,
    parameter int unsigned       WR_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sample_valid,
    input  logic [15:0]       i_data,
    input  logic              i_cmd_rec,
    input  logic              i_cmd_play,
    input  logic              i_cmd_dub,
    input  logic              i_cmd_stop,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [15:0]       o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq_in,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N,
    output logic [15:0]       o_loop_data,
    output logic              o_loop_valid,
    output logic [ADDR_W-1:0] o_loop_len,
    output logic [1:0]        o_mode,
    output logic              o_overrun
);

    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] ptr_inc;
    logic              ptr_clr;
    logic              overrun_q, overrun_d;
    logic              seq_req, seq_busy, seq_done;
    acc_op_e           seq_op;

    // Commands first (priority stop > rec > dub > play), then the completion
    // pointer step evaluated under the post-command mode; any clear wins.
    always_comb begin
        mode_d  = mode_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        ptr_clr = 1'b0;
        ptr_inc = ptr_q + ADDR_W'(1);
        case (mode_q)
            MODE_IDLE: begin
                if (!i_cmd_stop) begin
                    if (i_cmd_rec) begin
                        mode_d  = MODE_REC;
                        len_d   = '0;
                        ptr_clr = 1'b1;
                    end else if (!i_cmd_dub && i_cmd_play && (len_q != '0)) begin
                        mode_d  = MODE_PLAY;
                        ptr_clr = 1'b1;
                    end
                end
            end
            MODE_REC: begin
                if (i_cmd_stop || (!i_cmd_rec && !i_cmd_dub && i_cmd_play)) begin
                    len_d   = ptr_q;
                    ptr_clr = 1'b1;
                    mode_d  = (ptr_q != '0) ? MODE_PLAY : MODE_IDLE;
                end else if (i_cmd_rec) begin
                    len_d   = '0;
                    ptr_clr = 1'b1;
                end
            end
            MODE_PLAY: begin
                if (i_cmd_stop) begin
                    mode_d = MODE_IDLE;
                end else if (i_cmd_rec) begin
                    mode_d  = MODE_REC;
                    len_d   = '0;
                    ptr_clr = 1'b1;
                end else if (i_cmd_dub) begin
                    mode_d = MODE_DUB;
                end
            end
            MODE_DUB: begin
                if (i_cmd_stop) begin
                    mode_d = MODE_IDLE;
                end else if (i_cmd_rec) begin
                    mode_d  = MODE_REC;
                    len_d   = '0;
                    ptr_clr = 1'b1;
                end else if (!i_cmd_dub && i_cmd_play) begin
                    mode_d = MODE_PLAY;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase

        if (seq_done && !ptr_clr) begin
            case (mode_d)
                MODE_REC: begin
                    if (ptr_inc == MAX_LEN) begin
                        len_d   = MAX_LEN;
                        ptr_clr = 1'b1;
                        mode_d  = MODE_PLAY;
                    end else begin
                        ptr_d = ptr_inc;
                    end
                end
                MODE_PLAY, MODE_DUB: ptr_d = (ptr_inc == len_d) ? '0 : ptr_inc;
                default: ptr_d = ptr_q;
            endcase
        end

        if (ptr_clr) begin
            ptr_d = '0;
        end
    end

    always_comb begin
        seq_req   = i_sample_valid && !seq_busy && (mode_q != MODE_IDLE);
        overrun_d = i_sample_valid && seq_busy;
        case (mode_q)
            MODE_REC: seq_op = OP_WRITE;
            MODE_DUB: seq_op = OP_RMW;
            default:  seq_op = OP_READ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q    <= MODE_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            overrun_q <= overrun_d;
        end
    end

    sram_access_seq #(
        .ADDR_W (ADDR_W),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) u_seq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (seq_req),
        .i_op         (seq_op),
        .i_addr       (ptr_q),
        .i_wdata      (i_data),
        .o_busy       (seq_busy),
        .o_done       (seq_done),
        .o_rd_valid   (o_loop_valid),
        .o_rdata      (o_loop_data),
        .o_SRAM_ADDR  (o_SRAM_ADDR),
        .o_sram_dq_out(o_sram_dq_out),
        .o_sram_dq_oe (o_sram_dq_oe),
        .i_sram_dq_in (i_sram_dq_in),
        .o_SRAM_WE_N  (o_SRAM_WE_N),
        .o_SRAM_CE_N  (o_SRAM_CE_N),
        .o_SRAM_OE_N  (o_SRAM_OE_N),
        .o_SRAM_LB_N  (o_SRAM_LB_N),
        .o_SRAM_UB_N  (o_SRAM_UB_N)
    );

    always_comb begin
        o_mode     = mode_q;
        o_loop_len = len_q;
        o_overrun  = overrun_q;
    end

endmodule

// File: tb/tb_sram_loop_ctrl.sv
// Directed bench for sram_loop_ctrl with a small behavioural SRAM and bus monitor.
module tb_sram_loop_ctrl;

    logic        clk = 1'b0;
    logic        i_rst, i_sample_valid, i_cmd_rec, i_cmd_play, i_cmd_dub, i_cmd_stop;
    logic [15:0] i_data, sram_dq_in, o_sram_dq_out, o_loop_data;
    logic [19:0] o_SRAM_ADDR, o_loop_len;
    logic        o_sram_dq_oe, o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N;
    logic        o_loop_valid, o_overrun;
    logic [1:0]  o_mode;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [16];
    logic [19:0] wr_addr_q [$];
    int          wr_len_q [$];
    int          wr_run = 0;
    logic [19:0] wr_cur = '0;
    int          cnt_valid = 0, cnt_overrun = 0, cnt_strobe = 0, cnt_badbus = 0;

    always #5 clk = ~clk;

    sram_loop_ctrl #(
        .ADDR_W (20),
        .MAX_LEN(20'd8),
        .RD_WAIT(2),
        .WR_WAIT(2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_sample_valid(i_sample_valid),
        .i_data        (i_data),
        .i_cmd_rec     (i_cmd_rec),
        .i_cmd_play    (i_cmd_play),
        .i_cmd_dub     (i_cmd_dub),
        .i_cmd_stop    (i_cmd_stop),
        .o_SRAM_ADDR   (o_SRAM_ADDR),
        .o_sram_dq_out (o_sram_dq_out),
        .o_sram_dq_oe  (o_sram_dq_oe),
        .i_sram_dq_in  (sram_dq_in),
        .o_SRAM_WE_N   (o_SRAM_WE_N),
        .o_SRAM_CE_N   (o_SRAM_CE_N),
        .o_SRAM_OE_N   (o_SRAM_OE_N),
        .o_SRAM_LB_N   (o_SRAM_LB_N),
        .o_SRAM_UB_N   (o_SRAM_UB_N),
        .o_loop_data   (o_loop_data),
        .o_loop_valid  (o_loop_valid),
        .o_loop_len    (o_loop_len),
        .o_mode        (o_mode),
        .o_overrun     (o_overrun)
    );

    assign sram_dq_in = (!o_SRAM_OE_N && !o_SRAM_CE_N) ? mem[o_SRAM_ADDR[3:0]] : 16'h0000;

    // SRAM model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!o_SRAM_WE_N && !o_SRAM_CE_N) mem[o_SRAM_ADDR[3:0]] <= o_sram_dq_out;
        if (!o_SRAM_WE_N) begin
            wr_run <= wr_run + 1;
            wr_cur <= o_SRAM_ADDR;
        end else if (wr_run != 0) begin
            wr_addr_q.push_back(wr_cur);
            wr_len_q.push_back(wr_run);
            wr_run <= 0;
        end
        if (o_loop_valid) cnt_valid <= cnt_valid + 1;
        if (o_overrun) cnt_overrun <= cnt_overrun + 1;
        if (!o_SRAM_CE_N || !o_SRAM_WE_N || !o_SRAM_OE_N || !o_SRAM_LB_N || !o_SRAM_UB_N)
            cnt_strobe <= cnt_strobe + 1;
        if ((o_sram_dq_oe && !o_SRAM_OE_N) || (o_sram_dq_oe != !o_SRAM_WE_N))
            cnt_badbus <= cnt_badbus + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_cmd(input logic s, input logic r, input logic d, input logic p);
        i_cmd_stop = s; i_cmd_rec = r; i_cmd_dub = d; i_cmd_play = p;
        tick();
        i_cmd_stop = 0; i_cmd_rec = 0; i_cmd_dub = 0; i_cmd_play = 0;
    endtask

    task automatic pulse_sample(input logic [15:0] d);
        i_sample_valid = 1'b1;
        i_data = d;
        tick();
        i_sample_valid = 1'b0;
    endtask

    // lat counts cycles from the pulse cycle to the cycle o_loop_valid is seen.
    task automatic sample_read(input logic [15:0] d, input int settle, output int lat, output logic [15:0] data);
        pulse_sample(d);
        lat = 1;
        while (!o_loop_valid && lat < 12) begin
            tick();
            lat++;
        end
        data = o_loop_data;
        idle_ticks(settle);
    endtask

    task automatic test_reset();
        i_rst = 1; i_sample_valid = 0; i_data = 0;
        i_cmd_rec = 0; i_cmd_play = 0; i_cmd_dub = 0; i_cmd_stop = 0;
        idle_ticks(3);
        checks++;
        if ({o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, o_sram_dq_oe} !== 6'b111110) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=111110",
                     {o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, o_sram_dq_oe});
        end
        checks++;
        if (o_mode !== 2'd0 || o_loop_len !== 20'd0 || o_SRAM_ADDR !== 20'd0) begin
            failures++;
            $display("FAIL reset_state mode=%0d len=%0d addr=%0d exp=0/0/0", o_mode, o_loop_len, o_SRAM_ADDR);
        end
        checks++;
        if (o_loop_data !== 16'd0 || o_loop_valid !== 1'b0 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs data=%0d valid=%b overrun=%b exp=0/0/0", o_loop_data, o_loop_valid, o_overrun);
        end
        i_rst = 0;
        tick();
    endtask

    task automatic test_idle_samples();
        int b_s, b_v, b_o;
        b_s = cnt_strobe; b_v = cnt_valid; b_o = cnt_overrun;
        for (int i = 0; i < 5; i++) begin
            pulse_sample(16'(i * 7 + 1));
            idle_ticks(3);
        end
        checks++;
        if ((cnt_strobe - b_s) != 0 || (cnt_valid - b_v) != 0 || (cnt_overrun - b_o) != 0) begin
            failures++;
            $display("FAIL idle_activity strobes=%0d valid=%0d overrun=%0d exp=0/0/0",
                     cnt_strobe - b_s, cnt_valid - b_v, cnt_overrun - b_o);
        end
        checks++;
        if (o_loop_len !== 20'd0 || o_mode !== 2'd0) begin
            failures++;
            $display("FAIL idle_len len=%0d mode=%0d exp=0/0", o_loop_len, o_mode);
        end
    endtask

    task automatic test_record();
        logic [15:0] vals [4];
        int base;
        vals = '{16'd100, 16'd200, 16'd300, 16'd400};
        base = wr_addr_q.size();
        pulse_cmd(0, 1, 0, 0);
        checks++;
        if (o_mode !== 2'd1) begin
            failures++;
            $display("FAIL rec_mode got=%0d exp=1", o_mode);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_sample(vals[i]);
            idle_ticks(4);
        end
        pulse_cmd(0, 0, 0, 1);
        checks++;
        if (o_loop_len !== 20'd4 || o_mode !== 2'd2) begin
            failures++;
            $display("FAIL rec_commit len=%0d mode=%0d exp=4/2", o_loop_len, o_mode);
        end
        checks++;
        if (wr_addr_q.size() - base != 4) begin
            failures++;
            $display("FAIL rec_write_count got=%0d exp=4", wr_addr_q.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== 20'(i) || wr_len_q[base + i] != 2 || mem[i] !== vals[i]) begin
                failures++;
                $display("FAIL rec_write%0d addr=%0d we_cycles=%0d data=%0d exp=%0d/2/%0d",
                         i, wr_addr_q[base + i], wr_len_q[base + i], mem[i], i, vals[i]);
            end
        end
    endtask

    task automatic test_playback();
        logic [15:0] exp [8];
        int lat;
        logic [15:0] d;
        exp = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd100, 16'd200, 16'd300, 16'd400};
        for (int i = 0; i < 8; i++) begin
            sample_read(16'd0, 2, lat, d);
            checks++;
            if (lat != 3 || d !== exp[i]) begin
                failures++;
                $display("FAIL play%0d latency=%0d data=%0d exp=3/%0d", i, lat, d, exp[i]);
            end
        end
    endtask

    task automatic test_dub();
        int lat, base;
        logic [15:0] d;
        logic [15:0] exp [4];
        exp = '{16'h7FFF, 16'd150, 16'd300, 16'd400};
        base = wr_addr_q.size();
        pulse_cmd(0, 0, 1, 0);
        checks++;
        if (o_mode !== 2'd3) begin
            failures++;
            $display("FAIL dub_mode got=%0d exp=3", o_mode);
        end
        sample_read(16'd32700, 5, lat, d);
        checks++;
        if (lat != 3 || d !== 16'd100) begin
            failures++;
            $display("FAIL dub_read0 latency=%0d data=%0d exp=3/100", lat, d);
        end
        sample_read(16'hFFCE, 5, lat, d);
        checks++;
        if (lat != 3 || d !== 16'd200) begin
            failures++;
            $display("FAIL dub_read1 latency=%0d data=%0d exp=3/200", lat, d);
        end
        pulse_cmd(0, 0, 0, 1);
        checks++;
        if (wr_addr_q.size() - base != 2 || wr_addr_q[base] !== 20'd0 || wr_addr_q[base + 1] !== 20'd1
            || wr_len_q[base] != 2 || wr_len_q[base + 1] != 2) begin
            failures++;
            $display("FAIL dub_writes count=%0d addr0=%0d addr1=%0d exp=2/0/1",
                     wr_addr_q.size() - base, wr_addr_q[base], wr_addr_q[base + 1]);
        end
        checks++;
        if (mem[0] !== 16'h7FFF || mem[1] !== 16'd150 || o_mode !== 2'd2) begin
            failures++;
            $display("FAIL dub_mix mem0=%0d mem1=%0d mode=%0d exp=32767/150/2", mem[0], mem[1], o_mode);
        end
        sample_read(16'd0, 2, lat, d);
        sample_read(16'd0, 2, lat, d);
        for (int i = 0; i < 4; i++) begin
            sample_read(16'd0, 2, lat, d);
            checks++;
            if (d !== exp[i]) begin
                failures++;
                $display("FAIL dub_pass%0d data=%0d exp=%0d", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int b_v, b_o, lat;
        logic [15:0] d;
        b_v = cnt_valid; b_o = cnt_overrun;
        i_data = 16'd0;
        i_sample_valid = 1'b1;
        tick();
        tick();
        i_sample_valid = 1'b0;
        idle_ticks(6);
        checks++;
        if ((cnt_overrun - b_o) != 1 || (cnt_valid - b_v) != 1 || o_loop_data !== 16'h7FFF) begin
            failures++;
            $display("FAIL overrun_pulse overruns=%0d valids=%0d data=%0d exp=1/1/32767",
                     cnt_overrun - b_o, cnt_valid - b_v, o_loop_data);
        end
        sample_read(16'd0, 2, lat, d);
        checks++;
        if (d !== 16'd150) begin
            failures++;
            $display("FAIL overrun_ptr data=%0d exp=150", d);
        end
        sample_read(16'd0, 2, lat, d);
        sample_read(16'd0, 2, lat, d);
        checks++;
        if (cnt_badbus != 0) begin
            failures++;
            $display("FAIL bus_contention cycles=%0d exp=0", cnt_badbus);
        end
    endtask

    task automatic test_stop_play_same();
        int lat;
        logic [15:0] d;
        pulse_cmd(0, 1, 0, 0);
        checks++;
        if (o_mode !== 2'd1 || o_loop_len !== 20'd0) begin
            failures++;
            $display("FAIL rerec_mode mode=%0d len=%0d exp=1/0", o_mode, o_loop_len);
        end
        pulse_sample(16'd11); idle_ticks(4);
        pulse_sample(16'd22); idle_ticks(4);
        pulse_sample(16'd33); idle_ticks(4);
        pulse_cmd(1, 0, 0, 1);
        checks++;
        if (o_mode !== 2'd2 || o_loop_len !== 20'd3) begin
            failures++;
            $display("FAIL stop_play mode=%0d len=%0d exp=2/3", o_mode, o_loop_len);
        end
        sample_read(16'd0, 2, lat, d);
        pulse_cmd(1, 0, 0, 0);
        checks++;
        if (o_mode !== 2'd0 || o_loop_len !== 20'd3) begin
            failures++;
            $display("FAIL stop_retain mode=%0d len=%0d exp=0/3", o_mode, o_loop_len);
        end
        pulse_cmd(0, 0, 0, 1);
        sample_read(16'd0, 2, lat, d);
        checks++;
        if (o_mode !== 2'd2 || d !== 16'd11) begin
            failures++;
            $display("FAIL replay_start mode=%0d data=%0d exp=2/11", o_mode, d);
        end
    endtask

    task automatic test_auto_commit();
        int lat;
        logic [15:0] d;
        pulse_cmd(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            pulse_sample(16'(1000 + i));
            idle_ticks(4);
        end
        checks++;
        if (o_mode !== 2'd1 || o_loop_len !== 20'd0) begin
            failures++;
            $display("FAIL maxlen_early mode=%0d len=%0d exp=1/0", o_mode, o_loop_len);
        end
        pulse_sample(16'd1007);
        idle_ticks(4);
        checks++;
        if (o_mode !== 2'd2 || o_loop_len !== 20'd8 || mem[7] !== 16'd1007) begin
            failures++;
            $display("FAIL maxlen_commit mode=%0d len=%0d mem7=%0d exp=2/8/1007", o_mode, o_loop_len, mem[7]);
        end
        sample_read(16'd0, 2, lat, d);
        checks++;
        if (d !== 16'd1000) begin
            failures++;
            $display("FAIL maxlen_wrap data=%0d exp=1000", d);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        pulse_cmd(0, 0, 1, 0);
        pulse_sample(16'd5);
        n = 0;
        while (o_SRAM_WE_N && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (o_SRAM_WE_N !== 1'b0) begin
            failures++;
            $display("FAIL midwrite_reach we_n=%b exp=0", o_SRAM_WE_N);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if ({o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, o_sram_dq_oe} !== 6'b111110) begin
            failures++;
            $display("FAIL midwrite_strobes got=%b exp=111110",
                     {o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N, o_sram_dq_oe});
        end
        checks++;
        if (o_mode !== 2'd0 || o_loop_len !== 20'd0) begin
            failures++;
            $display("FAIL midwrite_state mode=%0d len=%0d exp=0/0", o_mode, o_loop_len);
        end
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_samples();
        test_record();
        test_playback();
        test_dub();
        test_overrun();
        test_stop_play_same();
        test_auto_commit();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
